// File: rtl/max7219_chain_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : max7219_chain_driver_if
// Description : Request/status bundle between the display-refresh client and
//               the MAX7219 chain driver. The optional display-test request
//               line exists only when MAX7219_DISPLAY_TEST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface max7219_chain_driver_if #(
    parameter int NUM_DEV    = 1,
    parameter int NUM_DIGITS = 8
);
    logic                            i_start;
    logic [NUM_DEV*NUM_DIGITS*8-1:0] i_digits;
    logic [3:0]                      i_intensity;
`ifdef MAX7219_DISPLAY_TEST_EN
    logic                            i_display_test;
`endif
    logic                            o_busy;
    logic                            o_done;

`ifdef MAX7219_DISPLAY_TEST_EN
    modport master (output i_start, i_digits, i_intensity, i_display_test,
                    input  o_busy, o_done);
    modport slave  (input  i_start, i_digits, i_intensity, i_display_test,
                    output o_busy, o_done);
`else
    modport master (output i_start, i_digits, i_intensity,
                    input  o_busy, o_done);
    modport slave  (input  i_start, i_digits, i_intensity,
                    output o_busy, o_done);
`endif
endinterface
`default_nettype wire

// File: rtl/max7219_chain_driver.sv
`default_nettype none
// ============================================================================
// Module      : max7219_chain_driver
// Description : Serial driver for a daisy chain of MAX7219 display chips.
//               Initialises the chain after reset, then on request writes
//               every digit of every chip over DIN/CLK/LOAD. Each frame is
//               one register write to all chips, furthest chip first.
//               Define MAX7219_DISPLAY_TEST_EN to add a display-test request
//               that is forwarded to register 0x0F on change.
// Revision    : 1.0 - initial release
// ============================================================================
module max7219_chain_driver #(
    parameter int NUM_DEV    = 1,
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_en,
    max7219_chain_driver_if.slave ctrl,
    output logic                  o_serial_dout,
    output logic                  o_serial_load,
    output logic                  o_serial_clk
);

    localparam int              NB         = 16 * NUM_DEV;
    localparam int              BIT_W      = $clog2(NB);
    localparam int              CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NB - 1);
    localparam logic [3:0]      INIT_LAST  = 4'd4;
    localparam logic [3:0]      DIG_LAST   = 4'(NUM_DIGITS - 1);
    localparam logic [7:0]      SCAN_LIMIT = 8'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LATCH    = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEQ_INIT     = 2'd0,
        SEQ_CFG_INT  = 2'd1,
        SEQ_CFG_TEST = 2'd2,
        SEQ_REFRESH  = 2'd3
    } seq_t;

    state_t                          state_q;
    seq_t                            seq_q, seq_d;
    logic [3:0]                      idx_q, idx_d;
    logic                            init_done_q, init_done_d;
    logic                            pend_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [BIT_W-1:0]                bit_q;
    logic [NB-1:0]                   sr_q;
    logic [NUM_DEV*NUM_DIGITS*8-1:0] digits_q;
    logic [3:0]                      int_buf_q, int_shadow_q;
    logic                            need_test_q, test_buf_q, test_shadow_q;
    logic                            busy_q, done_q, dout_q, load_q, sclk_q;

    logic                            frame_end_d, launch_d, accept_d, done_d, seq_end_d;
    logic                            test_live_d, need_int_d, need_test_d;
    logic [NUM_DEV*NUM_DIGITS*8-1:0] dig_src_d;
    logic [3:0]                      int_src_d;
    logic                            test_src_d;
    logic [7:0]                      addr_d, data_d;
    logic [NB-1:0]                   frame_d;

`ifdef MAX7219_DISPLAY_TEST_EN
    assign test_live_d = ctrl.i_display_test;
`else
    assign test_live_d = 1'b0;
`endif

    assign need_int_d  = (ctrl.i_intensity != int_shadow_q);
    assign need_test_d = (test_live_d != test_shadow_q);
    assign frame_end_d = (state_q == ST_GAP) && (cnt_q == CNT_LAST);

    // Decide whether a frame starts this cycle and which register write it is
    always_comb begin
        launch_d    = 1'b0;
        accept_d    = 1'b0;
        done_d      = 1'b0;
        seq_end_d   = 1'b0;
        init_done_d = init_done_q;
        seq_d       = seq_q;
        idx_d       = idx_q;
        if (state_q == ST_IDLE) begin
            if (i_en) begin
                if (!init_done_q) begin
                    // resume INIT at the next unsent write
                    launch_d = 1'b1;
                    seq_d    = SEQ_INIT;
                end else if (ctrl.i_start || pend_q) begin
                    accept_d = 1'b1;
                end
            end
        end else if (frame_end_d) begin
            case (seq_q)
                SEQ_INIT: begin
                    if (idx_q == INIT_LAST) begin
                        init_done_d = 1'b1;
                        seq_end_d   = 1'b1;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        launch_d = i_en;
                    end
                end
                SEQ_CFG_INT: begin
                    idx_d    = 4'd0;
                    seq_d    = need_test_q ? SEQ_CFG_TEST : SEQ_REFRESH;
                    launch_d = i_en;
                end
                SEQ_CFG_TEST: begin
                    idx_d    = 4'd0;
                    seq_d    = SEQ_REFRESH;
                    launch_d = i_en;
                end
                default: begin
                    if (idx_q == DIG_LAST) begin
                        done_d    = 1'b1;
                        seq_end_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        launch_d = i_en;
                    end
                end
            endcase
            // a request arriving during (or exactly at the end of) a sequence restarts at once
            if (seq_end_d && i_en && (ctrl.i_start || pend_q)) begin
                accept_d = 1'b1;
            end
        end
        if (accept_d) begin
            launch_d = 1'b1;
            idx_d    = 4'd0;
            if (need_int_d) begin
                seq_d = SEQ_CFG_INT;
            end else if (need_test_d) begin
                seq_d = SEQ_CFG_TEST;
            end else begin
                seq_d = SEQ_REFRESH;
            end
        end
    end

    // Build the chain-wide shift word for the frame selected above
    always_comb begin
        dig_src_d  = accept_d ? ctrl.i_digits    : digits_q;
        int_src_d  = accept_d ? ctrl.i_intensity : int_buf_q;
        test_src_d = accept_d ? test_live_d      : test_buf_q;
        addr_d     = 8'h00;
        data_d     = 8'h00;
        frame_d    = '0;
        case (seq_d)
            SEQ_INIT: begin
                case (idx_d)
                    4'd0:    begin addr_d = 8'h0C; data_d = 8'h01;                     end
                    4'd1:    begin addr_d = 8'h09; data_d = 8'h00;                     end
                    4'd2:    begin addr_d = 8'h0B; data_d = SCAN_LIMIT;                end
                    4'd3:    begin addr_d = 8'h0A; data_d = {4'h0, ctrl.i_intensity}; end
                    default: begin addr_d = 8'h0F; data_d = 8'h00;                     end
                endcase
            end
            SEQ_CFG_INT: begin
                addr_d = 8'h0A;
                data_d = {4'h0, int_src_d};
            end
            SEQ_CFG_TEST: begin
                addr_d = 8'h0F;
                data_d = {7'h00, test_src_d};
            end
            default: begin
                addr_d = {4'h0, idx_d} + 8'd1;
            end
        endcase
        for (int d = 0; d < NUM_DEV; d++) begin
            if (seq_d == SEQ_REFRESH) begin
                frame_d[d*16 +: 16] = {addr_d, dig_src_d[((d * NUM_DIGITS) + int'(idx_d)) * 8 +: 8]};
            end else begin
                frame_d[d*16 +: 16] = {addr_d, data_d};
            end
        end
    end

    // Sequencer bookkeeping plus the bit-level serial FSM with registered pins
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            seq_q         <= SEQ_INIT;
            idx_q         <= 4'd0;
            init_done_q   <= 1'b0;
            pend_q        <= 1'b0;
            cnt_q         <= '0;
            bit_q         <= '0;
            sr_q          <= '0;
            digits_q      <= '0;
            int_buf_q     <= 4'h0;
            int_shadow_q  <= 4'h0;
            need_test_q   <= 1'b0;
            test_buf_q    <= 1'b0;
            test_shadow_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            dout_q        <= 1'b0;
            load_q        <= 1'b0;
            sclk_q        <= 1'b0;
        end else begin
            done_q      <= done_d;
            init_done_q <= init_done_d;
            seq_q       <= seq_d;
            idx_q       <= idx_d;

            // requests while busy coalesce into one pending restart
            if (!i_en || accept_d) begin
                pend_q <= 1'b0;
            end else if (ctrl.i_start) begin
                pend_q <= 1'b1;
            end

            // whole-frame capture so a refresh never mixes old and new digits
            if (accept_d) begin
                digits_q    <= ctrl.i_digits;
                int_buf_q   <= ctrl.i_intensity;
                need_test_q <= need_test_d;
                test_buf_q  <= test_live_d;
            end

            // shadows track what the chips have been told
            if (launch_d && (seq_d != SEQ_REFRESH)) begin
                if (addr_d == 8'h0A) begin
                    int_shadow_q <= data_d[3:0];
                end
                if (addr_d == 8'h0F) begin
                    test_shadow_q <= data_d[0];
                end
            end

            if (launch_d) begin
                state_q <= ST_SHIFT_LO;
                cnt_q   <= '0;
                bit_q   <= '0;
                sr_q    <= frame_d;
                dout_q  <= frame_d[NB-1];
                sclk_q  <= 1'b0;
                load_q  <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_SHIFT_LO: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            sclk_q  <= 1'b1;
                            state_q <= ST_SHIFT_HI;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_SHIFT_HI: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q  <= '0;
                            sclk_q <= 1'b0;
                            if (bit_q == BIT_LAST) begin
                                dout_q  <= 1'b0;
                                load_q  <= 1'b1;
                                state_q <= ST_LATCH;
                            end else begin
                                bit_q   <= bit_q + 1'b1;
                                sr_q    <= sr_q << 1;
                                dout_q  <= sr_q[NB-2];
                                state_q <= ST_SHIFT_LO;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_LATCH: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            load_q  <= 1'b0;
                            state_q <= ST_GAP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ctrl.o_busy   = busy_q;
    assign ctrl.o_done   = done_q;
    assign o_serial_dout = dout_q;
    assign o_serial_load = load_q;
    assign o_serial_clk  = sclk_q;

endmodule
`default_nettype wire
